// File: rtl/rf_sequencer.sv
// Multi-cycle register-to-register sequencer: owns both read ports and the write port
// of a 16x8 register file, stepping each instruction through READ, EXEC and WRITE.
module rf_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    input  logic [7:0]  rd1,
    input  logic [7:0]  rd2,
    output logic [3:0]  wa3,
    output logic [7:0]  wd3,
    output logic        we3,
    output logic        done,
    output logic        illegal,
    output logic        zero,
    output logic        carry
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned INSTR_W = 16;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_LDI = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W:0]     res_q;
    logic [DATA_W:0]     alu_c;
    logic [ADDR_W-1:0]   ra1_q;
    logic [ADDR_W-1:0]   ra2_q;
    logic [ADDR_W-1:0]   wa3_q;
    logic                zero_q;
    logic                carry_q;
    logic                accept_c;
    logic                upd_zero_c;
    logic                upd_carry_c;
    logic [3:0]          op;

    assign op    = instr_q[15:12];
    assign ra1   = ra1_q;
    assign ra2   = ra2_q;
    assign wa3   = wa3_q;
    assign wd3   = res_q[DATA_W-1:0];
    assign zero  = zero_q;
    assign carry = carry_q;

    // Next-state and state-decoded strobes; reset gates ready and the write strobes
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        accept_c    = 1'b0;
        we3         = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        upd_zero_c  = 1'b0;
        upd_carry_c = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = rst_n;
                accept_c    = rst_n & instr_valid;
                if (accept_c) state_d = READ;
            end
            READ:  state_d = EXEC;
            EXEC:  state_d = WRITE;
            WRITE: begin
                state_d     = IDLE;
                done        = rst_n;
                illegal     = rst_n & (op > OP_CMP);
                we3         = rst_n & (op >= OP_MOV) & (op <= OP_XOR);
                upd_zero_c  = (op >= OP_MOV) & (op <= OP_CMP);
                upd_carry_c = (op == OP_ADD) | (op == OP_SUB) | (op == OP_CMP);
            end
            default: state_d = IDLE;
        endcase
    end

    // 9-bit ALU; bit 8 is carry for ADD and borrow for SUB/CMP
    always_comb begin
        alu_c = '0;
        case (op)
            OP_MOV:         alu_c = {1'b0, a_q};
            OP_LDI:         alu_c = {1'b0, instr_q[7:0]};
            OP_ADD:         alu_c = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB, OP_CMP: alu_c = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:         alu_c = {1'b0, a_q & b_q};
            OP_OR:          alu_c = {1'b0, a_q | b_q};
            OP_XOR:         alu_c = {1'b0, a_q ^ b_q};
            default:        alu_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            wa3_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                instr_q <= instr;
                ra1_q   <= instr[7:4];
                ra2_q   <= instr[3:0];
            end
            if (state_q == READ) begin
                a_q <= rd1;
                b_q <= rd2;
            end
            if (state_q == EXEC) begin
                res_q <= alu_c;
                wa3_q <= instr_q[11:8];
            end
            if (upd_zero_c)  zero_q  <= (res_q[DATA_W-1:0] == DATA_W'(0));
            if (upd_carry_c) carry_q <= res_q[DATA_W];
        end
    end

endmodule
